// File: rtl/kyber_decrypt_core.sv
// Baby-Kyber decryption stage: w = v - s^T*u in Z_Q[x]/(x^N+1), computed with one serial MAC,
// then each coefficient is decoded to a message bit. K and N must be powers of two (K >= 2).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | in_ready high; an accept captures u/v/s and clears acc
// S_MAC    | K*N*N product steps, walking p (outer), i, j (inner)
// S_REDUCE | one cycle: w = (v - acc) mod Q, decode bits, register outputs
// S_OUT    | out_valid high; outputs held until out_ready
module kyber_decrypt_core #(
  parameter int Q  = 17,
  parameter int N  = 4,
  parameter int K  = 2,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K*N*DW-1:0] u_in,
  input  logic [N*DW-1:0]   v_in,
  input  logic [K*N*DW-1:0] s_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      msg_out,
  output logic [N*5-1:0]    w_out
);

  localparam int MACS = K * N * N;
  localparam int CW   = $clog2(MACS);
  localparam int IW   = $clog2(N);
  localparam int PW   = $clog2(K);
  localparam logic [CW-1:0]        MAC_LAST = CW'(MACS - 1);
  localparam logic signed [DW-1:0] QS       = DW'(Q);
  localparam logic signed [DW-1:0] QS3      = DW'(3 * Q);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_REDUCE,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]        mac_cnt_q, mac_cnt_d;
  logic signed [DW-1:0] u_q   [K][N];
  logic signed [DW-1:0] s_q   [K][N];
  logic signed [DW-1:0] v_q   [N];
  logic signed [DW-1:0] acc_q [N];
  logic signed [DW-1:0] acc_d [N];
  logic [N-1:0]         msg_q, msg_d;
  logic [N*5-1:0]       w_q, w_d;

  logic                 accept;
  logic [CW-1:0]        mac_idx;
  logic [PW-1:0]        p_sel;
  logic [IW-1:0]        i_sel, j_sel, k_sel;
  logic                 k_wrap;
  logic signed [DW-1:0] prod;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign msg_out   = msg_q;
  assign w_out     = w_q;
  assign accept    = in_valid && in_ready;

  // The step counter runs down to zero; the product index counts up from it.
  assign mac_idx                = MAC_LAST - mac_cnt_q;
  assign {p_sel, i_sel, j_sel}  = mac_idx;
  assign {k_wrap, k_sel}        = {1'b0, i_sel} + {1'b0, j_sel};
  assign prod                   = DW'(s_q[p_sel][i_sel] * u_q[p_sel][j_sel]);

  always_comb begin
    logic signed [DW-1:0] t;
    logic signed [DW-1:0] r;
    logic signed [DW-1:0] w;
    logic signed [DW-1:0] w4;
    state_d   = state_q;
    mac_cnt_d = mac_cnt_q;
    acc_d     = acc_q;
    msg_d     = msg_q;
    w_d       = w_q;
    t         = '0;
    r         = '0;
    w         = '0;
    w4        = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d   = S_MAC;
          mac_cnt_d = MAC_LAST;
          for (int k = 0; k < N; k++) acc_d[k] = '0;
        end
      end
      S_MAC: begin
        // x^N = -1: a product landing at degree >= N folds back with a sign flip
        if (k_wrap) acc_d[k_sel] = acc_q[k_sel] - prod;
        else        acc_d[k_sel] = acc_q[k_sel] + prod;
        if (mac_cnt_q == '0) state_d = S_REDUCE;
        else                 mac_cnt_d = mac_cnt_q - CW'(1);
      end
      S_REDUCE: begin
        for (int i = 0; i < N; i++) begin
          t  = v_q[i] - acc_q[i];
          r  = t % QS;
          w  = (r + QS) % QS;
          w4 = w <<< 2;
          w_d[i*5 +: 5]  = 5'(w);
          msg_d[N-1-i]   = (w4 > QS) && (w4 < QS3);
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mac_cnt_q <= '0;
      msg_q     <= '0;
      w_q       <= '0;
      for (int k = 0; k < N; k++) acc_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      mac_cnt_q <= mac_cnt_d;
      msg_q     <= msg_d;
      w_q       <= w_d;
      for (int k = 0; k < N; k++) acc_q[k] <= acc_d[k];
    end
  end

  // Operand capture needs no reset: it is always reloaded before being used.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      for (int p = 0; p < K; p++) begin
        for (int j = 0; j < N; j++) begin
          u_q[p][j] <= u_in[(p*N + j)*DW +: DW];
          s_q[p][j] <= s_in[(p*N + j)*DW +: DW];
        end
      end
      for (int i = 0; i < N; i++) v_q[i] <= v_in[i*DW +: DW];
    end
  end

endmodule

// File: tb/tb_kyber_decrypt_core.sv
// Randomized bench for kyber_decrypt_core against a polynomial-arithmetic reference model.
module tb_kyber_decrypt_core;

  localparam int Q  = 17;
  localparam int N  = 4;
  localparam int K  = 2;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [K*N*DW-1:0] u_in = '0;
  logic [N*DW-1:0]   v_in = '0;
  logic [K*N*DW-1:0] s_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [N-1:0]      msg_out;
  logic [N*5-1:0]    w_out;

  int n_checks = 0;
  int n_errors = 0;

  int s_m [K][N];
  int u_m [K][N];
  int v_m [N];
  int exp_w [N];
  logic [N-1:0] exp_msg;

  kyber_decrypt_core #(.Q(Q), .N(N), .K(K), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .u_in      (u_in),
    .v_in      (v_in),
    .s_in      (s_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .msg_out   (msg_out),
    .w_out     (w_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int modq(input int x);
    return ((x % Q) + Q) % Q;
  endfunction

  // Coefficient k of s^T*u in Z[x]/(x^N+1), via full product then fold.
  function automatic int stu_coef(input int k);
    int c [2*N];
    for (int a = 0; a < 2*N; a++) c[a] = 0;
    for (int p = 0; p < K; p++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          c[i+j] += s_m[p][i] * u_m[p][j];
    return c[k] - c[k+N];
  endfunction

  function automatic void model();
    exp_msg = '0;
    for (int i = 0; i < N; i++) begin
      exp_w[i] = modq(v_m[i] - stu_coef(i));
      exp_msg[N-1-i] = (4*exp_w[i] > Q) && (4*exp_w[i] < 3*Q);
    end
  endfunction

  task automatic drive_inputs();
    for (int p = 0; p < K; p++)
      for (int j = 0; j < N; j++) begin
        u_in[(p*N + j)*DW +: DW] = u_m[p][j];
        s_in[(p*N + j)*DW +: DW] = s_m[p][j];
      end
    for (int i = 0; i < N; i++) v_in[i*DW +: DW] = v_m[i];
  endtask

  task automatic randomize_operands(input int s_mag, input int u_mag, input int v_mag);
    for (int p = 0; p < K; p++)
      for (int j = 0; j < N; j++) begin
        s_m[p][j] = int'($urandom_range(2*s_mag)) - s_mag;
        u_m[p][j] = int'($urandom_range(2*u_mag)) - u_mag;
      end
    for (int i = 0; i < N; i++) v_m[i] = int'($urandom_range(2*v_mag)) - v_mag;
  endtask

  task automatic clear_operands();
    for (int p = 0; p < K; p++)
      for (int j = 0; j < N; j++) begin
        s_m[p][j] = 0;
        u_m[p][j] = 0;
      end
    for (int i = 0; i < N; i++) v_m[i] = 0;
  endtask

  // Leaves time at #1 after the accept edge.
  task automatic accept_txn(input string tag);
    drive_inputs();
    check($sformatf("%s.in_ready", tag), in_ready, 1);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check($sformatf("%s.busy", tag), in_ready, 0);
  endtask

  task automatic finish_txn(input string tag, input int bp);
    int cyc;
    logic [25:0] snap;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check($sformatf("%s.latency", tag), cyc, 33);
    model();
    for (int i = 0; i < N; i++)
      check($sformatf("%s.w[%0d]", tag, i), w_out[i*5 +: 5], exp_w[i]);
    check($sformatf("%s.msg", tag), msg_out, exp_msg);
    snap = {out_valid, in_ready, msg_out, w_out};
    in_valid = 1'b1;
    for (int c = 0; c < bp; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s.hold%0d", tag, c), {out_valid, in_ready, msg_out, w_out}, snap);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check($sformatf("%s.ov_drop", tag), out_valid, 0);
    check($sformatf("%s.ready_back", tag), in_ready, 1);
    check($sformatf("%s.msg_kept", tag), msg_out, exp_msg);
  endtask

  initial begin
    logic [N-1:0] m;
    int e2;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.msg", msg_out, 0);
    check("rst.w", w_out, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // zero key
    clear_operands();
    randomize_operands(0, 16, 0);
    v_m[0] = 9; v_m[1] = 0; v_m[2] = 9; v_m[3] = 0;
    accept_txn("zero");
    finish_txn("zero", 0);
    check("zero.msg_abs", msg_out, 4'b1010);

    // negative wrap
    clear_operands();
    v_m[0] = -8; v_m[1] = -17; v_m[2] = 4; v_m[3] = 13;
    accept_txn("negw");
    finish_txn("negw", 2);
    check("negw.msg_abs", msg_out, 4'b1000);
    check("negw.w0_abs", w_out[4:0], 9);

    // negacyclic product x^3 * x = -1
    clear_operands();
    s_m[0][3] = 1; u_m[0][1] = 1; v_m[0] = 8;
    accept_txn("ncyc");
    finish_txn("ncyc", 0);
    check("ncyc.w0_abs", w_out[4:0], 9);
    check("ncyc.msg_abs", msg_out, 4'b1000);

    // backpressure with in_valid asserted during OUT
    randomize_operands(3, 16, 40);
    accept_txn("bp");
    finish_txn("bp", 10);

    // round trip: v = s^T*u + e2 + ceil(Q/2)*bit, coefficient i carries bit N-1-i
    for (int mi = 0; mi < 16; mi++) begin
      m = 4'(mi);
      randomize_operands(2, 16, 0);
      for (int i = 0; i < N; i++) begin
        e2 = int'($urandom_range(2)) - 1;
        v_m[i] = stu_coef(i) + e2 + (m[N-1-i] ? 9 : 0) + Q * (int'($urandom_range(4)) - 2);
      end
      accept_txn($sformatf("rt%0d", mi));
      finish_txn($sformatf("rt%0d", mi), mi % 3);
      check($sformatf("rt%0d.msg_abs", mi), msg_out, m);
    end

    // reset after 15 MAC steps, then a fresh accept
    randomize_operands(5, 100, 100);
    accept_txn("rstmac");
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rstmac.in_ready", in_ready, 1);
    check("rstmac.out_valid", out_valid, 0);
    check("rstmac.msg", msg_out, 0);
    check("rstmac.w", w_out, 0);
    randomize_operands(3, 16, 40);
    accept_txn("fresh");
    finish_txn("fresh", 1);

    // random transactions
    for (int r = 0; r < 20; r++) begin
      randomize_operands(4, 64, 200);
      accept_txn($sformatf("rnd%0d", r));
      finish_txn($sformatf("rnd%0d", r), int'($urandom_range(3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
